// File: rtl/avalon_master_arbiter.sv
// avalon_master_arbiter: N-to-1 Avalon-MM master mux with round-robin grant
// and in-order read tag FIFO. Macro ARB_CH0_PRIORITY_EN: ch0 always wins.
module avalon_master_arbiter #(
  parameter int NUM_CH          = 3,
  parameter int ADDR_W          = 26,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH*ADDR_W-1:0]   s_address,
  input  logic [NUM_CH-1:0]          s_read,
  input  logic [NUM_CH-1:0]          s_write,
  input  logic [NUM_CH*DATA_W/8-1:0] s_byteenable,
  input  logic [NUM_CH*DATA_W-1:0]   s_writedata,
  output logic [NUM_CH-1:0]          s_waitrequest,
  output logic [DATA_W-1:0]          s_readdata,
  output logic [NUM_CH-1:0]          s_readdatavalid,
  output logic [ADDR_W-1:0]          m_address,
  output logic                       m_read,
  output logic                       m_write,
  output logic [DATA_W/8-1:0]        m_byteenable,
  output logic [DATA_W-1:0]          m_writedata,
  input  logic                       m_waitrequest,
  input  logic [DATA_W-1:0]          m_readdata,
  input  logic                       m_readdatavalid,
  output logic                       protocol_err
);
  localparam int BE_W = DATA_W / 8;
  localparam int CW   = $clog2(NUM_CH);
  localparam int FW   = $clog2(MAX_OUTSTANDING);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     grant_q, grant_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     win, idx;
  logic              win_vld;
  logic [NUM_CH-1:0] req, rr_req;
  logic [CW-1:0]     fifo_q [MAX_OUTSTANDING];
  logic [FW-1:0]     wr_q, rd_q;
  logic [FW:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              g_rd, g_wr;
  logic              full, accept, push, pop;

  assign req          = s_read | s_write;
  assign full         = (cnt_q == (FW+1)'(MAX_OUTSTANDING));
  assign pop          = m_readdatavalid & (cnt_q != '0);
  assign s_readdata   = m_readdata;
  assign protocol_err = err_q;

  // Winner: first requester after the pointer, wrapping
  always_comb begin
    win     = '0;
    idx     = '0;
    win_vld = 1'b0;
    rr_req  = req;
`ifdef ARB_CH0_PRIORITY_EN
    rr_req[0] = 1'b0;
    win_vld   = req[0];
`endif
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CW'((int'(ptr_q) + k) % NUM_CH);
      if (!win_vld && rr_req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Grant FSM next state and downstream command mux
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    err_d         = err_q;
    m_address     = '0;
    m_byteenable  = '0;
    m_writedata   = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    s_waitrequest = '1;
    accept        = 1'b0;
    push          = 1'b0;
    g_rd          = s_read[grant_q];
    g_wr          = s_write[grant_q];
    if (|(s_read & s_write))
      err_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = win;
          state_d = BUSY;
        end
      end
      BUSY: begin
        m_address    = s_address[grant_q*ADDR_W +: ADDR_W];
        m_byteenable = s_byteenable[grant_q*BE_W +: BE_W];
        m_writedata  = s_writedata[grant_q*DATA_W +: DATA_W];
        m_read       = g_rd & ~full;
        m_write      = g_wr & ~g_rd;
        accept       = (m_read | m_write) & ~m_waitrequest;
        if (accept) begin
          s_waitrequest[grant_q] = 1'b0;
          push    = g_rd;
          ptr_d   = grant_q;
          state_d = IDLE;
        end else if (!g_rd && !g_wr) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (m_readdatavalid && !pop)
      err_d = 1'b1;
  end

  // Read return strobe routed from FIFO head
  always_comb begin
    s_readdatavalid = '0;
    if (pop)
      s_readdatavalid[fifo_q[rd_q]] = 1'b1;
  end

  // Tag count; simultaneous push and pop cancel
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= CW'(NUM_CH - 1);
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (push)
        wr_q <= wr_q + 1'b1;
      if (pop)
        rd_q <= rd_q + 1'b1;
    end
  end

  // Tag storage, no reset needed
  always_ff @(posedge clock) begin
    if (push)
      fifo_q[wr_q] <= grant_q;
  end

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// tb_avalon_master_arbiter: random traffic against a transaction-level
// model of grant order, tag routing, read blocking and error flag.
module tb_avalon_master_arbiter;
  localparam int N  = 3;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 8;
  localparam int CYCLES = 1300;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N*AW-1:0]   s_address = '0;
  logic [N-1:0]      s_read = '0;
  logic [N-1:0]      s_write = '0;
  logic [N*BW-1:0]   s_byteenable = '0;
  logic [N*DW-1:0]   s_writedata = '0;
  logic [N-1:0]      s_waitrequest;
  logic [DW-1:0]     s_readdata;
  logic [N-1:0]      s_readdatavalid;
  logic [AW-1:0]     m_address;
  logic              m_read;
  logic              m_write;
  logic [BW-1:0]     m_byteenable;
  logic [DW-1:0]     m_writedata;
  logic              m_waitrequest = 1'b0;
  logic [DW-1:0]     m_readdata = '0;
  logic              m_readdatavalid = 1'b0;
  logic              protocol_err;

  avalon_master_arbiter #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clock(clock), .reset(reset),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Upstream channel intents
  bit            rq_rd [N];
  bit            rq_wr [N];
  logic [AW-1:0] ad [N];
  logic [DW-1:0] wd [N];
  logic [BW-1:0] be [N];

  // Reference model: current grant (-1 none), last winner, tag queue
  int  cur;
  int  last;
  int  tags [$];
  bit  err;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } ret_t;
  ret_t pend [$];

  logic [N-1:0]  e_wait, e_rdv;
  logic          e_mr, e_mw, acc;
  logic [AW-1:0] e_ad;
  logic [BW-1:0] e_be;
  logic [DW-1:0] e_wd;

  function automatic int pick();
    int r = -1;
`ifdef ARB_CH0_PRIORITY_EN
    if (rq_rd[0] || rq_wr[0])
      return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int c = (last + k) % N;
      if (r < 0 && (rq_rd[c] || rq_wr[c]))
        r = c;
    end
    return r;
  endfunction

  task automatic model_reset();
    cur  = -1;
    last = N - 1;
    tags.delete();
    err  = 1'b0;
  endtask

  initial begin
    bit gen, fill, ret_en, rst_now;
    for (int i = 0; i < N; i++) begin
      rq_rd[i] = 1'b0;
      rq_wr[i] = 1'b0;
      ad[i] = '0;
      wd[i] = '0;
      be[i] = '0;
    end
    model_reset();
    @(posedge clock);
    #1;
    for (int c = 0; c < CYCLES; c++) begin
      rst_now = (c == 0) || (c == 300) || (c == 995);
      gen     = !(c >= 900 && c < 995);
      fill    = (c >= 400 && c < 600);
      ret_en  = !fill;
      // drive phase
      reset = rst_now;
      if (rst_now)
        model_reset();
      for (int i = 0; i < N; i++) begin
        if (!rq_rd[i] && !rq_wr[i] && gen && $urandom_range(2) != 0) begin
          if (fill || $urandom_range(1) == 1)
            rq_rd[i] = 1'b1;
          else
            rq_wr[i] = 1'b1;
          ad[i] = AW'($urandom);
          wd[i] = DW'($urandom);
          be[i] = BW'($urandom);
        end
        s_read[i]               = rq_rd[i];
        s_write[i]              = rq_wr[i];
        s_address[i*AW +: AW]   = ad[i];
        s_writedata[i*DW +: DW] = wd[i];
        s_byteenable[i*BW +: BW] = be[i];
      end
      m_waitrequest   = ($urandom_range(3) == 0);
      m_readdatavalid = 1'b0;
      m_readdata      = DW'($urandom);
      if (ret_en && pend.size() > 0 && pend[0].due <= c
          && $urandom_range(1) == 1) begin
        m_readdatavalid = 1'b1;
        m_readdata      = pend[0].d;
        void'(pend.pop_front());
      end
      if (c == 990)
        m_readdatavalid = 1'b1;

      // compare phase
      @(negedge clock);
      e_wait = '1;
      e_mr = 1'b0;
      e_mw = 1'b0;
      e_ad = '0;
      e_be = '0;
      e_wd = '0;
      acc  = 1'b0;
      if (cur >= 0) begin
        e_mr = rq_rd[cur] && (tags.size() < MO);
        e_mw = rq_wr[cur] && !rq_rd[cur];
        e_ad = ad[cur];
        e_be = be[cur];
        e_wd = wd[cur];
        acc  = (e_mr || e_mw) && !m_waitrequest;
        if (acc)
          e_wait[cur] = 1'b0;
      end
      e_rdv = '0;
      if (m_readdatavalid && tags.size() > 0)
        e_rdv[tags[0]] = 1'b1;
      check("s_waitrequest", 64'(s_waitrequest), 64'(e_wait));
      check("m_read", 64'(m_read), 64'(e_mr));
      check("m_write", 64'(m_write), 64'(e_mw));
      check("m_address", 64'(m_address), 64'(e_ad));
      check("m_byteenable", 64'(m_byteenable), 64'(e_be));
      check("m_writedata", 64'(m_writedata), 64'(e_wd));
      check("s_readdatavalid", 64'(s_readdatavalid), 64'(e_rdv));
      check("protocol_err", 64'(protocol_err), 64'(err));
      if (e_rdv != '0)
        check("s_readdata", 64'(s_readdata), 64'(m_readdata));

      // model update at the clock edge
      @(posedge clock);
      if (!rst_now) begin
        if (m_readdatavalid) begin
          if (tags.size() > 0)
            void'(tags.pop_front());
          else
            err = 1'b1;
        end
        for (int i = 0; i < N; i++)
          if (rq_rd[i] && rq_wr[i])
            err = 1'b1;
        if (cur < 0) begin
          cur = pick();
        end else if (acc) begin
          last = cur;
          if (e_mr) begin
            ret_t r;
            tags.push_back(cur);
            r.d   = DW'($urandom);
            r.due = c + 1 + int'($urandom_range(5));
            pend.push_back(r);
          end
          rq_rd[cur] = 1'b0;
          rq_wr[cur] = 1'b0;
          cur = -1;
        end else if (!rq_rd[cur] && !rq_wr[cur]) begin
          err = 1'b1;
          cur = -1;
        end
      end
      #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
